// File: rtl/ysyx_24100029_ifu_pcgen.sv
// ysyx_24100029_ifu_pcgen
// Instruction-fetch front end. It owns the fetch PC and issues one I-cache
// request at a time. Returned instructions, tagged with their PC and predicted-taken
// bit, are buffered in a circular fetch queue for decode. A backend redirect
// reloads the PC, flushes the queue and discards any in-flight response.
//
// Optional feature: define YSYX_24100029_IFU_BPU_EN to follow the branch
// predictor (next PC = bpu_npc). If it is undefined, the front end fetches
// static not-taken (next PC = pc + 4, pred = 0).
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   bpu_pc               current fetch PC driven to the predictor
//   bpu_npc, bpu_pred    predicted next PC / taken flag for bpu_pc
//   ic_req_*             cache request (valid/ready/addr, addr == bpu_pc)
//   ic_resp_*            cache response (one per accepted request)
//   redirect_valid/pc    backend redirect pulse and target
//   if_*                 fetch-queue head towards decode (valid/ready handshake)
module ysyx_24100029_ifu_pcgen #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] bpu_pc,
  input  logic [31:0] bpu_npc,
  input  logic        bpu_pred,
  output logic        ic_req_valid,
  input  logic        ic_req_ready,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_pred
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, DROP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc;
  logic [31:0]   pend_pc;
  logic          pend_pred;
  logic [31:0]   next_pc;
  logic          next_pred;
  logic          req_fire;
  logic          push;
  logic          pop;

  logic [31:0]   fq_inst [FQ_DEPTH];
  logic [31:0]   fq_pc   [FQ_DEPTH];
  logic          fq_pred [FQ_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

`ifdef YSYX_24100029_IFU_BPU_EN
  assign next_pc   = bpu_npc;
  assign next_pred = bpu_pred;
`else
  logic unused_bpu;
  assign unused_bpu = ^{bpu_npc, bpu_pred};
  assign next_pc    = pc + 32'd4;
  assign next_pred  = 1'b0;
`endif

  assign bpu_pc      = pc;
  assign ic_req_addr = pc;

  // Redirect suppresses both the request and the queue update, so a flush
  // never races with a new handshake or a push/pop on the same edge.
  assign req_fire = ic_req_valid & ic_req_ready;
  assign push     = (state == WAIT) & ic_resp_valid & ~redirect_valid;
  assign pop      = if_valid & if_ready & ~redirect_valid;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT: state_nxt = REQ;
      REQ:  if (req_fire) state_nxt = WAIT;
      WAIT: begin
        if (ic_resp_valid)       state_nxt = REQ;
        else if (redirect_valid) state_nxt = DROP;
      end
      DROP: if (ic_resp_valid) state_nxt = REQ;
      default: state_nxt = BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    ic_req_valid = 1'b0;
    if (state == REQ) ic_req_valid = (count < FULL) & ~redirect_valid;
  end

  // Fetch PC, pending request tag and queue control
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      pend_pc   <= '0;
      pend_pred <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (req_fire) begin
        pend_pc   <= pc;
        pend_pred <= next_pred;
        pc        <= next_pc;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clock) begin
    if (push) begin
      fq_inst[wr_ptr] <= ic_resp_inst;
      fq_pc[wr_ptr]   <= pend_pc;
      fq_pred[wr_ptr] <= pend_pred;
    end
  end

  assign if_valid = (count != '0);
  assign if_inst  = if_valid ? fq_inst[rd_ptr] : '0;
  assign if_pc    = if_valid ? fq_pc[rd_ptr]   : '0;
  assign if_pred  = if_valid ? fq_pred[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_ysyx_24100029_ifu_pcgen.sv
// Testbench for ysyx_24100029_ifu_pcgen: a cache responder with configurable
// latency, a combinational predictor stub, and a scoreboard of expected
// fetch-queue entries (pushed when a response is accepted, popped on decode).
module tb_ysyx_24100029_ifu_pcgen;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;
  localparam int unsigned FQ_DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [31:0] bpu_pc;
  logic [31:0] bpu_npc;
  logic        bpu_pred;
  logic        ic_req_valid;
  logic        ic_req_ready;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_pred;

  ysyx_24100029_ifu_pcgen #(
    .RESET_PC(RESET_PC),
    .FQ_DEPTH(FQ_DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bpu_pc        (bpu_pc),
    .bpu_npc       (bpu_npc),
    .bpu_pred      (bpu_pred),
    .ic_req_valid  (ic_req_valid),
    .ic_req_ready  (ic_req_ready),
    .ic_req_addr   (ic_req_addr),
    .ic_resp_valid (ic_resp_valid),
    .ic_resp_inst  (ic_resp_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .if_pred       (if_pred)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Predictor stub: taken at one chosen PC, otherwise sequential.
  logic        taken_en;
  logic [31:0] taken_pc;
  logic [31:0] taken_tgt;
  assign bpu_pred = taken_en && (bpu_pc == taken_pc);
  assign bpu_npc  = bpu_pred ? taken_tgt : bpu_pc + 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  ent_t        expq[$];
  ent_t        pend_e;
  logic        pend_live;
  logic [31:0] exp_pc;
  logic        boot;
  logic        cache_pending;
  int          cache_wait;
  logic [31:0] cache_addr;
  int          lat;
  int          hs_count;
  logic [31:0] last_hs_addr;
  int          checks;
  int          errors;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic model_pred(input logic [31:0] p);
`ifdef YSYX_24100029_IFU_BPU_EN
    return taken_en && (p == taken_pc);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_npc(input logic [31:0] p);
    return model_pred(p) ? taken_tgt : p + 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present cache/redirect inputs, check outputs, then
  // advance the reference model across the rising edge.
  task automatic cycle(input logic redir, input logic [31:0] rtgt);
    logic        hs;
    logic        pop;
    logic        exp_rv;
    logic [31:0] addr;
    ent_t        e;
    redirect_valid = redir;
    redirect_pc    = rtgt;
    ic_resp_valid  = cache_pending && (cache_wait == 0);
    ic_resp_inst   = ic_resp_valid ? inst_of(cache_addr) : '0;
    #1;
    exp_rv = !boot && !cache_pending && (expq.size() < FQ_DEPTH) && !redir;
    chk("bpu_pc", bpu_pc, exp_pc);
    chk("ic_req_addr", ic_req_addr, exp_pc);
    chk("ic_req_valid", {31'b0, ic_req_valid}, {31'b0, exp_rv});
    chk("if_valid", {31'b0, if_valid}, {31'b0, expq.size() != 0});
    hs   = ic_req_valid & ic_req_ready;
    addr = ic_req_addr;
    pop  = (expq.size() != 0) && if_ready && !redir;
    if (pop) begin
      e = expq[0];
      chk("if_inst", if_inst, e.inst);
      chk("if_pc", if_pc, e.pc);
      chk("if_pred", {31'b0, if_pred}, {31'b0, e.pred});
    end
    @(posedge clock);
    if (redir) begin
      exp_pc = rtgt;
      expq.delete();
      pend_live = 1'b0;
    end else begin
      if (pop) void'(expq.pop_front());
      if (ic_resp_valid && pend_live) expq.push_back(pend_e);
    end
    if (ic_resp_valid) begin
      cache_pending = 1'b0;
      pend_live     = 1'b0;
    end else if (cache_pending && cache_wait != 0) begin
      cache_wait--;
    end
    if (hs) begin
      cache_pending = 1'b1;
      cache_addr    = addr;
      cache_wait    = lat - 1;
      hs_count++;
      last_hs_addr  = addr;
      if (!redir) begin
        pend_e    = '{inst: inst_of(exp_pc), pc: exp_pc, pred: model_pred(exp_pc)};
        pend_live = 1'b1;
        exp_pc    = model_npc(exp_pc);
      end
    end
    boot = 1'b0;
    @(negedge clock);
  endtask

  // Asserted between edges so the reset values are checked before any clock.
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ic_resp_valid  = 1'b0;
    ic_resp_inst   = '0;
    #1;
    chk("rst_bpu_pc", bpu_pc, RESET_PC);
    chk("rst_ic_req_addr", ic_req_addr, RESET_PC);
    chk("rst_ic_req_valid", {31'b0, ic_req_valid}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_pred", {31'b0, if_pred}, 32'd0);
    cache_pending = 1'b0;
    cache_wait    = 0;
    pend_live     = 1'b0;
    expq.delete();
    exp_pc   = RESET_PC;
    boot     = 1'b1;
    hs_count = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_hs(input string tag, input logic [31:0] want);
    int start;
    start = hs_count;
    for (int i = 0; i < 20 && hs_count == start; i++) cycle(1'b0, '0);
    chk({tag, "_seen"}, {31'b0, hs_count != start}, 32'd1);
    chk(tag, last_hs_addr, want);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    int found;
    checks       = 0;
    errors       = 0;
    taken_en     = 1'b0;
    taken_pc     = 32'h3000_0004;
    taken_tgt    = 32'h3000_0100;
    lat          = 1;
    ic_req_ready = 1'b1;
    if_ready     = 1'b1;
    last_hs_addr = '0;
    reset        = 1'b1;
    @(negedge clock);

    // Sequential fetch, one-cycle cache, decode always ready.
    do_reset();
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, '0);
      if (first == 0 && if_valid) first = i;
    end
    chk("first_if_valid_cycle", 32'(first), 32'd3);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0);

    // Predicted taken at 3000_0004.
    do_reset();
    taken_en = 1'b1;
    wait_hs("pred_hs0", 32'h3000_0000);
    wait_hs("pred_hs1", 32'h3000_0004);
`ifdef YSYX_24100029_IFU_BPU_EN
    wait_hs("pred_hs2", 32'h3000_0100);
`else
    wait_hs("pred_hs2", 32'h3000_0008);
`endif
    for (int i = 0; i < 8; i++) cycle(1'b0, '0);
    taken_en = 1'b0;

    // Decode stalled: queue fills, requests stop; then drains in order.
    do_reset();
    if_ready = 1'b0;
    for (int i = 0; i < 20; i++) cycle(1'b0, '0);
    chk("fill_hs_count", 32'(hs_count), FQ_DEPTH);
    chk("fill_if_valid", {31'b0, if_valid}, 32'd1);
    if_ready = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b0, '0);
    chk("resume_hs", {31'b0, hs_count > FQ_DEPTH}, 32'd1);

    // Redirect while waiting; response arrives two cycles later.
    do_reset();
    lat      = 3;
    if_ready = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0);
    for (int i = 0; i < 20 && !cache_pending; i++) cycle(1'b0, '0);
    chk("wait_setup", {31'b0, cache_pending}, 32'd1);
    if_ready = 1'b1;
    cycle(1'b1, 32'h8000_0000);
    chk("redir_if_valid", {31'b0, if_valid}, 32'd0);
    chk("redir_bpu_pc", bpu_pc, 32'h8000_0000);
    wait_hs("redir_next_req", 32'h8000_0000);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0);

    // Redirect coinciding with the response that would fill the queue.
    do_reset();
    lat      = 1;
    if_ready = 1'b0;
    found    = 0;
    for (int i = 0; i < 30; i++) begin
      if (expq.size() == FQ_DEPTH - 1 && cache_pending && cache_wait == 0) begin
        found = 1;
        break;
      end
      cycle(1'b0, '0);
    end
    chk("full_resp_setup", 32'(found), 32'd1);
    cycle(1'b1, 32'h4000_0040);
    chk("full_redir_if_valid", {31'b0, if_valid}, 32'd0);
    wait_hs("full_redir_next_req", 32'h4000_0040);
    if_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b0, '0);

    // PC wrap at the top of the address space, with a throttled cache.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, '0);
    cycle(1'b1, 32'hFFFF_FFFC);
    wait_hs("wrap_req0", 32'hFFFF_FFFC);
    wait_hs("wrap_req1", 32'h0000_0000);
    for (int i = 0; i < 30; i++) begin
      ic_req_ready = 1'($urandom_range(0, 1));
      if_ready     = 1'($urandom_range(0, 1));
      cycle(1'b0, '0);
    end
    ic_req_ready = 1'b1;
    if_ready     = 1'b1;
    for (int i = 0; i < 12; i++) cycle(1'b0, '0);
    chk("final_drain", {31'b0, if_valid}, {31'b0, expq.size() != 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
